// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage between fetch and execute.
// Decodes one instruction word into an execute control bundle behind a
// valid/ready register, stalls fetch while a data-memory read completes,
// and pulses fetch_flush when a jump is issued so fetch drops its next word.
module instr_decode_stage #(
  parameter int INSTR_W    = 16,
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int MEM_ADDR_W = 10,
  parameter int PC_W       = 5,
  parameter int MEM_RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [INSTR_W-1:0]    in_instr,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            operation_code,
  output logic                  aku_enable,
  output logic                  reg_ce,
  output logic                  reg_wr,
  output logic [REG_ADDR_W-1:0] register_addr,
  output logic [MEM_ADDR_W-1:0] mem_adr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  direct_load,
  output logic [DATA_W-1:0]     direct_data,
  output logic                  counter_load,
  output logic [PC_W-1:0]       address_counter,
  output logic                  fetch_flush
);

  // Field layout must fit below the 4-bit opcode.
  if (DATA_W + 1 > INSTR_W - 4) begin : g_bad_data_w
    $error("instr_decode_stage: DATA_W+1 must not exceed INSTR_W-4");
  end
  if (MEM_ADDR_W > INSTR_W - 4) begin : g_bad_mem_addr_w
    $error("instr_decode_stage: MEM_ADDR_W must not exceed INSTR_W-4");
  end
  if (PC_W > INSTR_W - 4) begin : g_bad_pc_w
    $error("instr_decode_stage: PC_W must not exceed INSTR_W-4");
  end
  if (REG_ADDR_W > INSTR_W - 4) begin : g_bad_reg_addr_w
    $error("instr_decode_stage: REG_ADDR_W must not exceed INSTR_W-4");
  end
  if (MEM_RD_LAT < 0 || MEM_RD_LAT > 15) begin : g_bad_lat
    $error("instr_decode_stage: MEM_RD_LAT must be in 0..15");
  end

  localparam logic [3:0] LAT = 4'(MEM_RD_LAT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  typedef struct packed {
    logic [3:0]            op;
    logic                  aku;
    logic                  reg_ce;
    logic                  reg_wr;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [MEM_ADDR_W-1:0] mem_adr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  dload;
    logic [DATA_W-1:0]     ddata;
    logic                  cload;
    logic [PC_W-1:0]       pc;
  } bundle_t;

  // Opcode map; any field not used by an opcode stays 0.
  function automatic bundle_t decode(input logic [INSTR_W-1:0] ins);
    bundle_t b;
    logic    imm;
    b    = '0;
    b.op = ins[INSTR_W-1 -: 4];
    imm  = ins[DATA_W];
    case (b.op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        b.aku = 1'b1;
        if (imm) begin
          b.dload = 1'b1;
          b.ddata = ins[DATA_W-1:0];
        end else begin
          b.reg_addr = ins[REG_ADDR_W-1:0];
        end
      end
      4'h7: begin
        b.cload = 1'b1;
        b.pc    = ins[PC_W-1:0];
      end
      4'h8, 4'h9: begin
        b.reg_wr   = 1'b1;
        b.reg_addr = ins[REG_ADDR_W-1:0];
      end
      4'hA, 4'hB: begin
        b.mem_rd  = 1'b1;
        b.aku     = 1'b1;
        b.mem_adr = ins[MEM_ADDR_W-1:0];
      end
      4'hC, 4'hD: begin
        if (imm) begin
          b.dload = 1'b1;
          b.ddata = ins[DATA_W-1:0];
          b.aku   = 1'b1;
        end else begin
          b.reg_ce   = 1'b1;
          b.reg_addr = ins[REG_ADDR_W-1:0];
        end
      end
      4'hE, 4'hF: begin
        b.mem_wr  = 1'b1;
        b.mem_adr = ins[MEM_ADDR_W-1:0];
      end
      default: ; // NOP: opcode only
    endcase
    return b;
  endfunction

  state_t     r_state;
  logic [3:0] r_wait_cnt;
  logic       r_drop;
  logic       r_out_valid;
  logic       r_flush;
  bundle_t    r_bundle;

  bundle_t    w_dec;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_is_jmp;
  logic       w_is_ldm;

  assign w_dec      = decode(in_instr);
  assign w_in_ready = (r_state == RUN) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_is_jmp   = (w_dec.op == 4'h7);
  assign w_is_ldm   = (w_dec.op[3:1] == 3'b101);

  // ---- stage boundary: fetch -> registered decode bundle ----
  // Handshake, wait-state FSM, jump drop flag and the output bundle register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= 4'd0;
      r_drop      <= 1'b0;
      r_out_valid <= 1'b0;
      r_flush     <= 1'b0;
      r_bundle    <= '0;
    end else begin
      r_flush <= 1'b0;
      if (r_state == MEM_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
        if (r_wait_cnt == 4'd1) r_state <= RUN;
      end
      if (w_accept) begin
        if (r_drop) begin
          // Word fetched behind a jump: swallow it, emit nothing.
          r_drop      <= 1'b0;
          r_out_valid <= 1'b0;
          r_bundle    <= '0;
        end else begin
          r_out_valid <= 1'b1;
          r_bundle    <= w_dec;
          r_drop      <= w_is_jmp;
          r_flush     <= w_is_jmp;
          if (w_is_ldm && (LAT != 4'd0)) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= LAT;
          end
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_bundle    <= '0;
      end
    end
  end

  assign in_ready        = w_in_ready;
  assign out_valid       = r_out_valid;
  assign fetch_flush     = r_flush;
  assign operation_code  = r_bundle.op;
  assign aku_enable      = r_bundle.aku;
  assign reg_ce          = r_bundle.reg_ce;
  assign reg_wr          = r_bundle.reg_wr;
  assign register_addr   = r_bundle.reg_addr;
  assign mem_adr         = r_bundle.mem_adr;
  assign mem_rd          = r_bundle.mem_rd;
  assign mem_wr          = r_bundle.mem_wr;
  assign direct_load     = r_bundle.dload;
  assign direct_data     = r_bundle.ddata;
  assign counter_load    = r_bundle.cload;
  assign address_counter = r_bundle.pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed scenarios plus randomized traffic,
// compared each cycle against a behavioural model of the stage.
module tb_instr_decode_stage;

  localparam int MEM_RD_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'h0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [3:0]  operation_code;
  logic        aku_enable, reg_ce, reg_wr, mem_rd, mem_wr, direct_load, counter_load, fetch_flush;
  logic [2:0]  register_addr;
  logic [9:0]  mem_adr;
  logic [7:0]  direct_data;
  logic [4:0]  address_counter;

  instr_decode_stage #(
    .INSTR_W(16), .DATA_W(8), .REG_ADDR_W(3), .MEM_ADDR_W(10), .PC_W(5), .MEM_RD_LAT(MEM_RD_LAT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .operation_code(operation_code),
    .aku_enable(aku_enable), .reg_ce(reg_ce), .reg_wr(reg_wr), .register_addr(register_addr),
    .mem_adr(mem_adr), .mem_rd(mem_rd), .mem_wr(mem_wr), .direct_load(direct_load),
    .direct_data(direct_data), .counter_load(counter_load), .address_counter(address_counter),
    .fetch_flush(fetch_flush)
  );

  // Wider parameter set instance.
  logic        x_in_valid = 1'b0;
  logic [19:0] x_in_instr = 20'h0;
  logic        x_out_ready = 1'b1;
  logic        x_in_ready, x_out_valid;
  logic [3:0]  x_operation_code;
  logic        x_aku_enable, x_reg_ce, x_reg_wr, x_mem_rd, x_mem_wr, x_direct_load, x_counter_load, x_fetch_flush;
  logic [2:0]  x_register_addr;
  logic [13:0] x_mem_adr;
  logic [11:0] x_direct_data;
  logic [4:0]  x_address_counter;

  instr_decode_stage #(
    .INSTR_W(20), .DATA_W(12), .REG_ADDR_W(3), .MEM_ADDR_W(14), .PC_W(5), .MEM_RD_LAT(MEM_RD_LAT)
  ) u_dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_instr(x_in_instr), .in_ready(x_in_ready),
    .out_valid(x_out_valid), .out_ready(x_out_ready), .operation_code(x_operation_code),
    .aku_enable(x_aku_enable), .reg_ce(x_reg_ce), .reg_wr(x_reg_wr), .register_addr(x_register_addr),
    .mem_adr(x_mem_adr), .mem_rd(x_mem_rd), .mem_wr(x_mem_wr), .direct_load(x_direct_load),
    .direct_data(x_direct_data), .counter_load(x_counter_load), .address_counter(x_address_counter),
    .fetch_flush(x_fetch_flush)
  );

  logic [63:0] obs_bundle;
  assign obs_bundle = {27'd0, operation_code, aku_enable, reg_ce, reg_wr, register_addr, mem_adr,
                       mem_rd, mem_wr, direct_load, direct_data, counter_load, address_counter};

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid, m_flush, m_drop;
  int          m_wait;
  logic [63:0] m_bundle;

  function automatic logic [63:0] ref_bundle(input int unsigned ins);
    int unsigned op, imm, aku, rce, rwr, ra, ma, mrd, mwr, dl, dd, cl, ac;
    op  = ins / 4096;
    imm = (ins / 256) % 2;
    aku = 0; rce = 0; rwr = 0; ra = 0; ma = 0; mrd = 0; mwr = 0; dl = 0; dd = 0; cl = 0; ac = 0;
    if (op <= 5) begin
      aku = 1;
      if (imm == 1) begin dl = 1; dd = ins % 256; end
      else ra = ins % 8;
    end else if (op == 7) begin
      cl = 1; ac = ins % 32;
    end else if (op == 8 || op == 9) begin
      rwr = 1; ra = ins % 8;
    end else if (op == 10 || op == 11) begin
      mrd = 1; aku = 1; ma = ins % 1024;
    end else if (op == 12 || op == 13) begin
      if (imm == 1) begin dl = 1; dd = ins % 256; aku = 1; end
      else begin rce = 1; ra = ins % 8; end
    end else if (op >= 14) begin
      mwr = 1; ma = ins % 1024;
    end
    return {27'd0, op[3:0], aku[0], rce[0], rwr[0], ra[2:0], ma[9:0], mrd[0], mwr[0], dl[0],
            dd[7:0], cl[0], ac[4:0]};
  endfunction

  function automatic bit m_ready(input logic ordy);
    return (m_wait == 0) && (!m_valid || ordy);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_flush = 0; m_drop = 0; m_wait = 0; m_bundle = 64'd0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] ins, input logic ordy);
    bit acc;
    int unsigned op;
    acc = v && m_ready(ordy);
    op  = 32'(ins) / 4096;
    m_flush = 0;
    if (m_wait > 0) m_wait--;
    if (acc) begin
      if (m_drop) begin
        m_drop = 0; m_valid = 0; m_bundle = 64'd0;
      end else begin
        m_valid  = 1;
        m_bundle = ref_bundle(32'(ins));
        if (op == 7) begin m_drop = 1; m_flush = 1; end
        if ((op == 10 || op == 11) && MEM_RD_LAT > 0) m_wait = MEM_RD_LAT;
      end
    end else if (ordy) begin
      m_valid = 0; m_bundle = 64'd0;
    end
  endtask

  task automatic compare_all();
    check_eq("out_valid", out_valid, m_valid);
    check_eq("in_ready", in_ready, m_ready(out_ready));
    check_eq("fetch_flush", fetch_flush, m_flush);
    check_eq("bundle", obs_bundle, m_bundle);
  endtask

  // Called at a falling edge: drive, check current outputs, advance one cycle.
  task automatic cycle(input logic v, input logic [15:0] ins, input logic ordy);
    in_valid = v; in_instr = ins; out_ready = ordy;
    #1 compare_all();
    @(posedge clk);
    model_step(v, ins, ordy);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    // Power-on reset held across clock edges.
    @(negedge clk); @(negedge clk);
    #1 compare_all();
    check_eq("rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-stream asynchronous reset during a memory wait with a held bundle.
    cycle(1'b1, 16'hA3FF, 1'b0);
    #1 check_eq("pre_rst_mem_rd", mem_rd, 1);
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_eq("rst_out_valid_async", out_valid, 0);
    check_eq("rst_mem_rd_async", mem_rd, 0);
    check_eq("rst_bundle_async", obs_bundle, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 check_eq("rst_release_in_ready", in_ready, 1);

    // Back-to-back ALU ops.
    cycle(1'b1, 16'h0142, 1'b1);
    #1 check_eq("or_op", operation_code, 0);
    check_eq("or_dload", direct_load, 1);
    check_eq("or_ddata", direct_data, 8'h42);
    check_eq("or_aku", aku_enable, 1);
    cycle(1'b1, 16'h1003, 1'b1);
    #1 check_eq("sub_op", operation_code, 1);
    check_eq("sub_raddr", register_addr, 3);
    check_eq("sub_dload", direct_load, 0);

    // Memory load with read latency stall.
    cycle(1'b1, 16'hA3FF, 1'b1);
    #1 check_eq("ldm_adr", mem_adr, 10'h3FF);
    check_eq("ldm_rd", mem_rd, 1);
    check_eq("ldm_aku", aku_enable, 1);
    check_eq("ldm_wait1", in_ready, 0);
    cycle(1'b1, 16'h6000, 1'b1);
    #1 check_eq("ldm_wait2", in_ready, 0);
    check_eq("ldm_rd_drop", mem_rd, 0);
    cycle(1'b1, 16'h6000, 1'b1);
    #1 check_eq("ldm_wait_end", in_ready, 1);
    cycle(1'b0, 16'h0000, 1'b1);

    // Jump, then the following word is swallowed.
    cycle(1'b1, 16'h7015, 1'b1);
    #1 check_eq("jmp_cload", counter_load, 1);
    check_eq("jmp_target", address_counter, 5'h15);
    check_eq("jmp_flush", fetch_flush, 1);
    cycle(1'b1, 16'h0001, 1'b1);
    #1 check_eq("jmp_drop_valid", out_valid, 0);
    check_eq("jmp_flush_once", fetch_flush, 0);
    cycle(1'b0, 16'h0000, 1'b1);

    // Jump held by a stalled consumer: flush still a single pulse.
    cycle(1'b1, 16'h7003, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0);
    #1 check_eq("jmp_hold_valid", out_valid, 1);
    check_eq("jmp_hold_flush", fetch_flush, 0);
    cycle(1'b0, 16'h0000, 1'b1);
    // Jump arriving while the drop flag is set is itself dropped.
    cycle(1'b1, 16'h7004, 1'b1);
    #1 check_eq("jmp_dropped_valid", out_valid, 0);
    check_eq("jmp_dropped_flush", fetch_flush, 0);
    cycle(1'b1, 16'h0105, 1'b1);
    #1 check_eq("after_drop_ddata", direct_data, 8'h05);
    cycle(1'b0, 16'h0000, 1'b1);

    // Store held for three stalled cycles.
    cycle(1'b1, 16'hE010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("stm_wr", mem_wr, 1);
      check_eq("stm_adr", mem_adr, 10'h010);
      check_eq("stm_in_ready", in_ready, 0);
      cycle(1'b1, 16'h0107, 1'b0);
    end
    cycle(1'b1, 16'h0107, 1'b1);
    #1 check_eq("stm_next_valid", out_valid, 1);
    check_eq("stm_next_op", operation_code, 0);
    check_eq("stm_next_ddata", direct_data, 8'h07);

    // Wider parameter set.
    x_in_valid = 1'b1; x_in_instr = 20'h1_1ABC; x_out_ready = 1'b1;
    cycle(1'b0, 16'h0000, 1'b1);
    x_in_valid = 1'b0;
    #1 check_eq("wide_valid", x_out_valid, 1);
    check_eq("wide_op", x_operation_code, 1);
    check_eq("wide_ddata", x_direct_data, 12'hABC);
    check_eq("wide_dload", x_direct_load, 1);
    check_eq("wide_raddr", x_register_addr, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r;
      r = $urandom;
      cycle(($urandom % 10) < 7, r[15:0], ($urandom % 4) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered, parametrised successor of the combinational instruction decoder.
- Sits between instruction fetch (program memory and address counter) and the execute datapath (ALU and accumulator, register file, data memory).
- Adds a valid/ready pipeline register, a wait state for data-memory read latency, and a fetch-flush pulse on jumps.
- Widths of the instruction, data, register address, memory address and program counter fields are generics.

Parameters:
- INSTR_W, 16: instruction width. Opcode is always instr[INSTR_W-1:INSTR_W-4].
- DATA_W, 8: immediate width, taken from instr[DATA_W-1:0]. The immediate-select bit is instr[DATA_W].
- REG_ADDR_W, 3: register address width, taken from instr[REG_ADDR_W-1:0].
- MEM_ADDR_W, 10: data memory address width, taken from instr[MEM_ADDR_W-1:0].
- PC_W, 5: jump target width, taken from instr[PC_W-1:0].
- MEM_RD_LAT, 2: data-memory read latency in cycles, 0..15.
- Legality: DATA_W+1 <= INSTR_W-4, MEM_ADDR_W <= INSTR_W-4, PC_W <= INSTR_W-4. Violation is an elaboration error.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous reset, active low.
- in_valid, input, 1: fetch presents an instruction.
- in_instr, input, INSTR_W: instruction word.
- in_ready, output, 1: stage accepts the instruction this cycle.
- out_valid, output, 1: the decoded bundle below is valid.
- out_ready, input, 1: execute consumes the bundle.
- operation_code, output, 4: opcode.
- aku_enable, output, 1: accumulator write.
- reg_ce, output, 1: register file read to accumulator.
- reg_wr, output, 1: accumulator to register file write.
- register_addr, output, REG_ADDR_W: register address.
- mem_adr, output, MEM_ADDR_W: data memory address.
- mem_rd, output, 1: data memory read strobe.
- mem_wr, output, 1: data memory write strobe.
- direct_load, output, 1: immediate operand select.
- direct_data, output, DATA_W: immediate value.
- counter_load, output, 1: program counter load.
- address_counter, output, PC_W: jump target.
- fetch_flush, output, 1: one-cycle pulse; fetch discards its in-flight word.

Behaviour:
- Opcode map, with imm = instr[DATA_W]:
  - 0000..0101: ALU ops OR, SUB, AND_L, OR_L, XOR_L, NOT_L. aku_enable=1. If imm=1: direct_load=1 and direct_data set; else register_addr set.
  - 0110: NOP. All strobes 0.
  - 0111: JMP. counter_load=1, address_counter set.
  - 1000/1001: ST_R. reg_wr=1, register_addr set.
  - 1010/1011: LD_M. mem_rd=1, aku_enable=1, mem_adr set.
  - 1100/1101: LD. If imm=1: direct_load=1, direct_data set, aku_enable=1. Else reg_ce=1, register_addr set.
  - 1110/1111: ST_M. mem_wr=1, mem_adr set.
  - Every field not listed for an opcode is driven 0.
- Reset: all outputs 0 (including out_valid and fetch_flush). FSM goes to RUN, wait counter 0, drop flag 0. Reset takes effect immediately, including mid-wait; any held bundle is lost.
- FSM state RUN:
  - in_ready = !out_valid || out_ready.
  - Accept (in_valid && in_ready): the decoded bundle is registered and out_valid=1 in the next cycle. Latency is 1 cycle.
  - Simultaneous consume and accept: the new bundle replaces the old one with no bubble.
  - out_ready=1 with no accept: out_valid falls to 0 and all strobes fall to 0.
  - out_ready=0: the bundle is held stable.
- FSM state MEM_WAIT:
  - Entered on accepting LD_M when MEM_RD_LAT>0, with the counter loaded with MEM_RD_LAT.
  - in_ready=0. The counter decrements each cycle; the FSM returns to RUN on the cycle the counter reaches 0.
  - The bundle handshake on the output continues independently. mem_rd is 1 only while out_valid for the LD_M bundle.
- MEM_RD_LAT=0: MEM_WAIT is never entered.
- JMP:
  - fetch_flush=1 in the same cycle that the JMP bundle first shows out_valid. It is a single pulse even if out_ready stalls.
  - The next instruction accepted after the JMP is dropped: handshake completes, no bundle is produced, and the drop flag clears.
  - A JMP arriving while the drop flag is set is itself dropped.

Test Plan:
- Reset with rst_n=0 mid-stream -> all outputs 0 asynchronously, in_ready=1 after release with out_ready=1.
- in_instr=16'h0142 (OR, immediate) then 16'h1003 (SUB, R3), back-to-back with out_ready=1:
  - cycle 1: operation_code=0, direct_load=1, direct_data=8'h42, aku_enable=1.
  - cycle 2: operation_code=1, register_addr=3, direct_load=0.
- 16'hA3FF (LD_M) with MEM_RD_LAT=2 -> mem_adr=10'h3FF, mem_rd=1, aku_enable=1; in_ready=0 for exactly 2 cycles after accept.
- 16'h7015 (JMP) followed by 16'h0001 -> counter_load=1, address_counter=5'h15, fetch_flush pulses once; 16'h0001 is consumed and never appears on the output.
- out_ready=0 for 3 cycles holding 16'hE010 (ST_M) -> mem_wr=1, mem_adr=10'h010 stable, in_ready=0; the next bundle appears 1 cycle after out_ready=1.
- Parameter set INSTR_W=20, DATA_W=12, MEM_ADDR_W=14, with in_instr=20'h1_1ABC (SUB, imm=1) -> direct_data=12'hABC, direct_load=1.
